oh_dffpipe: RTL and testbench

Parametrised elastic register pipeline with valid/ready flow control. It is the handshaked successor to the plain D flip-flop: a DW-bit payload travels through DEPTH register stages, stalls without loss under back-pressure, and can be flushed. It is used for timing closure on long datapaths and for retiming between producer and consumer blocks.

---
 rtl/oh_dffpipe.sv | 93 +++++++++
 tb/tb_oh_dffpipe.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/oh_dffpipe.sv
// oh_dffpipe: elastic valid/ready register pipeline of DEPTH stages with flush
// Define OH_DFFPIPE_SKID_EN for two-entry skid stages with registered ready (capacity 2*DEPTH).
module oh_dffpipe #(
   parameter int DW = 32,
   parameter int DEPTH = 2,
   parameter logic [DW-1:0] RESETVAL = '0,
   parameter int CW = $clog2(2*DEPTH+1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic [CW-1:0] count
);
   logic [DEPTH-1:0] vld, load;
   logic [DEPTH:0]   rdy, src;
   logic [DW-1:0]    dat [DEPTH];
   logic [DW-1:0]    sd [DEPTH];
   logic             in_xfer, out_xfer;
   // src[i] is the valid offered to stage i; src[DEPTH] is the last stage's valid
   assign src = {vld, in_valid};
   assign rdy[DEPTH] = out_ready;
   assign sd[0] = in_data;
   for (genvar i = 1; i < DEPTH; i++) begin : g_sd
      assign sd[i] = dat[i-1];
   end
   assign load = {DEPTH{!clear}} & src[DEPTH-1:0] & rdy[DEPTH-1:0];
   assign in_ready = !reset && !clear && rdy[0];
   assign out_valid = src[DEPTH] && !clear;
   assign out_data = dat[DEPTH-1];
   assign in_xfer = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;
`ifdef OH_DFFPIPE_SKID_EN
   logic [DEPTH-1:0] sv;
   logic [DW-1:0]    sdat [DEPTH];
   // a stage accepts whenever its skid slot is free, so ready never sees out_ready
   assign rdy[DEPTH-1:0] = ~sv;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         vld <= '0;
         sv <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            dat[k] <= RESETVAL;
            sdat[k] <= RESETVAL;
         end
      end else if (clear) begin
         vld <= '0;
         sv <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++)
            if (sv[k]) begin
               if (rdy[k+1]) begin
                  dat[k] <= sdat[k];
                  sv[k] <= 1'b0;
               end
            end else if (load[k]) begin
               if (vld[k] && !rdy[k+1]) begin
                  sdat[k] <= sd[k];
                  sv[k] <= 1'b1;
               end else begin
                  dat[k] <= sd[k];
                  vld[k] <= 1'b1;
               end
            end else if (rdy[k+1]) vld[k] <= 1'b0;
      end
`else
   // the ready chain collapses to: out_ready, or a hole at or beyond this stage
   for (genvar i = 0; i < DEPTH; i++) begin : g_rdy
      assign rdy[i] = out_ready || !(&vld[DEPTH-1:i]);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         vld <= '0;
         for (int k = 0; k < DEPTH; k++) dat[k] <= RESETVAL;
      end else if (clear) begin
         vld <= '0;
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            vld[k] <= load[k] || (vld[k] && !rdy[k+1]);
            if (load[k]) dat[k] <= sd[k];
         end
      end
`endif
   always_ff @(posedge clk or posedge reset)
      if (reset) count <= '0;
      else if (clear) count <= '0;
      else count <= count + CW'(in_xfer) - CW'(out_xfer);
endmodule

// File: tb/tb_oh_dffpipe.sv
// tb_oh_dffpipe: directed and random checks of oh_dffpipe (DW=8, DEPTH=3, RESETVAL=0xA5)
// against a queue scoreboard; honours OH_DFFPIPE_SKID_EN for capacity.
module tb_oh_dffpipe;
`ifdef OH_DFFPIPE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif
   localparam int CAP = SKID ? 6 : 3;
   logic clk = 0, reset = 0, clear = 0, in_valid = 0, out_ready = 0;
   logic [7:0] in_data = 0;
   logic in_ready, out_valid;
   logic [7:0] out_data;
   logic [2:0] count;
   int checks = 0, errors = 0;
   logic [7:0] q[$];
   bit in_x, out_x, pv, pr, pc;
   logic [7:0] pd;
   logic [31:0] pcnt;
   int nin, nout, first, last, steady, gap;

   oh_dffpipe #(.DW(8), .DEPTH(3), .RESETVAL(8'hA5)) dut (
      .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .count(count)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one clock: protocol checks mid-cycle, then scoreboard update on the edge
   task automatic tick();
      @(negedge clk);
      chk("count", count, q.size());
      if (out_valid) begin
         if (q.size() == 0) chk("spurious_valid", out_valid, 1'b0);
         else chk("out_data", out_data, q[0]);
      end
      if (!reset && !clear && q.size() == 0) begin
         chk("empty_valid", out_valid, 1'b0);
         chk("empty_ready", in_ready, 1'b1);
      end
      if (!reset && !clear && q.size() == CAP) chk("full_ready", in_ready, SKID ? 1'b0 : out_ready);
      if (clear) begin
         chk("clr_ready", in_ready, 1'b0);
         chk("clr_valid", out_valid, 1'b0);
      end
      if (pv && !pr && !pc && !clear && !reset) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_data", out_data, pd);
      end
      in_x = in_valid && in_ready;
      out_x = out_valid && out_ready;
      pv = out_valid; pr = out_ready; pd = out_data; pc = clear; pcnt = 32'(count);
      @(posedge clk);
      if (reset || clear) q.delete();
      else begin
         if (out_x) void'(q.pop_front());
         if (in_x) q.push_back(in_data);
      end
      #1;
   endtask

   initial begin
      #2 reset = 1;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_data", out_data, 8'hA5);
      chk("rst_count", count, 0);
      chk("rst_ready", in_ready, 1'b0);
      reset = 0; #1;
      chk("rel_ready", in_ready, 1'b1);
      // streaming 0x01..0x10
      in_valid = 1; out_ready = 1; in_data = 8'h01;
      nin = 0; nout = 0; first = -1; last = -1; steady = 1;
      for (int c = 0; c < 40 && nout < 16; c++) begin
         tick();
         if (c >= 3 && c <= 16 && pcnt != 3) steady = 0;
         if (in_x) nin++;
         if (out_x) begin
            if (first < 0) first = c;
            last = c;
            nout++;
         end
         in_valid = (nin < 16);
         in_data = 8'(nin + 1);
      end
      chk("stream_first", first, 3);
      chk("stream_words", nout, 16);
      chk("stream_span", last - first, 15);
      chk("stream_steady", steady, 1);
      // back-pressure
      out_ready = 0; in_valid = 1; in_data = 8'h20; nin = 0;
      for (int c = 0; c < CAP + 4; c++) begin
         tick();
         if (in_x) begin nin++; in_data++; end
      end
      #1;
      chk("bp_accepted", nin, CAP);
      chk("bp_count", count, CAP);
      chk("bp_ready", in_ready, 1'b0);
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_data", out_data, 8'h20);
      in_valid = 0; out_ready = 1; gap = 0;
      for (int c = 0; c < CAP; c++) begin
         tick();
         if (!out_x) gap++;
      end
      #1;
      chk("bp_gaps", gap, 0);
      chk("bp_empty", count, 0);
      // simultaneous in/out at full
      out_ready = 0; in_valid = 1; in_data = 8'h40;
      for (int c = 0; c < CAP + 6 && count != CAP; c++) begin
         tick();
         if (in_x) in_data++;
      end
      chk("full_fill", count, CAP);
      out_ready = 1; nin = 0; nout = 0; steady = 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (in_x) begin nin++; in_data++; end
         if (out_x) nout++;
         if (count != CAP) steady = 0;
      end
      chk("sim_out", nout, 4);
`ifndef OH_DFFPIPE_SKID_EN
      chk("sim_in", nin, 4);
      chk("sim_steady", steady, 1);
`endif
      in_valid = 0;
      for (int c = 0; c < 20 && count != 0; c++) tick();
      chk("sim_drain", count, 0);
      // flush
      out_ready = 0; in_valid = 1; in_data = 8'h60;
      tick(); if (in_x) in_data++;
      tick();
      clear = 1; out_ready = 1; #1;
      chk("flush_pre_count", count, 2);
      chk("flush_in_ready", in_ready, 1'b0);
      chk("flush_out_valid", out_valid, 1'b0);
      tick();
      clear = 0; in_valid = 0; #1;
      chk("flush_count", count, 0);
      chk("flush_valid", out_valid, 1'b0);
      in_valid = 1; in_data = 8'h77;
      tick();
      chk("flush_acc", in_x, 1'b1);
      in_valid = 0; #1;
      chk("lat1", out_valid, 1'b0);
      tick(); #1;
      chk("lat2", out_valid, 1'b0);
      tick(); #1;
      chk("lat3", out_valid, 1'b1);
      chk("lat3_data", out_data, 8'h77);
      tick();
      // asynchronous reset mid-stream
      out_ready = 0; in_valid = 1; in_data = 8'h90;
      tick(); if (in_x) in_data++;
      tick();
      in_valid = 0;
      tick(); tick(); #1;
      chk("mid_count", count, 2);
      chk("mid_valid", out_valid, 1'b1);
      reset = 1; q.delete(); pv = 0; #1;
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_data", out_data, 8'hA5);
      chk("arst_count", count, 0);
      chk("arst_ready", in_ready, 1'b0);
      tick();
      reset = 0; out_ready = 1; #1;
      chk("arst_rel_ready", in_ready, 1'b1);
      nout = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (out_x) nout++;
      end
      chk("arst_no_stale", nout, 0);
      // random traffic
      for (int c = 0; c < 600; c++) begin
         in_valid = ($urandom % 4) != 0;
         out_ready = ($urandom % 3) != 0;
         in_data = 8'($urandom);
         clear = ($urandom % 32) == 0;
         tick();
      end
      clear = 0; in_valid = 0; out_ready = 1;
      for (int c = 0; c < 20 && count != 0; c++) tick();
      chk("final_empty", count, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
